divider_mem_ctrl: RTL and testbench

Scratch-memory sequencer on the far side of the divider datapath's memory interface. Walks a region of 128-bit scratch-memory lines in groups of two, reads each pair and presents it as the `sc_mem_rd_data1`/`sc_mem_rd_data2` + `sc_mem_rd_data_rdy` feed for the eight dividers. It then waits for all eight dividers to finish and issues the two write strobes and addresses timed to the datapath's `sc_mem_wt_data` sequence. The scratch memory takes write data directly from the datapath; this block supplies only the read data path and the control and addresses.

---
 rtl/divider_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_divider_mem_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_mem_ctrl.sv
`timescale 1ns / 1ps
// Scratch-memory sequencer for the eight-divider datapath: reads 128-bit line pairs, presents
// them to the dividers, then times the two result write strobes to the datapath's write sequence.
module divider_mem_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wt_base,
  input  logic [ADDR_W-1:0] num_groups,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [127:0]      mem_rd_data,
  output logic              mem_wt_en,
  output logic [ADDR_W-1:0] mem_wt_addr,
  input  logic [7:0]        div_done,
  output logic [127:0]      sc_mem_rd_data1,
  output logic [127:0]      sc_mem_rd_data2,
  output logic              sc_mem_rd_data_rdy,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    StIdle,
    StRd0,
    StRd1,
    StCap1,
    StPresent,
    StWaitDiv,
    StWrSeq,
    StNext,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] wt_base_q, wt_base_d;
  logic [ADDR_W-1:0] num_groups_q, num_groups_d;
  logic [ADDR_W-1:0] g_q, g_d, g_inc, g_off;
  logic              arm_q, arm_d;
  logic [2:0]        k_q, k_d;

  logic              rd_en_d, wt_en_d, rdy_d, busy_d, done_d;
  logic [ADDR_W-1:0] rd_addr_d, wt_addr_d;
  logic [127:0]      data1_d, data2_d;

  assign g_inc = g_q + ADDR_W'(1);

  // Sequencing: next state plus the bookkeeping registers.
  always_comb begin
    state_d      = state_q;
    rd_base_d    = rd_base_q;
    wt_base_d    = wt_base_q;
    num_groups_d = num_groups_q;
    g_d          = g_q;
    arm_d        = arm_q;
    k_d          = k_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rd_base_d    = rd_base;
          wt_base_d    = wt_base;
          num_groups_d = num_groups;
          g_d          = '0;
          state_d      = (num_groups == '0) ? StDone : StRd0;
        end
      end
      StRd0:     state_d = StRd1;
      StRd1:     state_d = StCap1;
      StCap1:    state_d = StPresent;
      StPresent: begin
        arm_d   = 1'b0;
        state_d = StWaitDiv;
      end
      StWaitDiv: begin
        // Only a full set of done flags seen after at least one low flag counts as this group's.
        if (arm_q && (div_done == 8'hFF)) begin
          k_d     = 3'd0;
          state_d = StWrSeq;
        end else if (div_done != 8'hFF) begin
          arm_d = 1'b1;
        end
      end
      StWrSeq: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd3) begin
          state_d = StNext;
        end
      end
      StNext: begin
        g_d = g_inc;
        if (g_inc == num_groups_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StRd0;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are computed from the upcoming state so strobes line up with it.
  always_comb begin
    g_off     = {g_d[ADDR_W-2:0], 1'b0};
    rd_en_d   = (state_d == StRd0) || (state_d == StRd1);
    rd_addr_d = '0;
    if (rd_en_d) begin
      rd_addr_d = rd_base_d + g_off + ADDR_W'(state_d == StRd1);
    end
    wt_en_d   = (state_d == StWrSeq) && ((k_d == 3'd0) || (k_d == 3'd3));
    wt_addr_d = '0;
    if (wt_en_d) begin
      wt_addr_d = wt_base_d + g_off + ADDR_W'(k_d == 3'd3);
    end
    rdy_d   = (state_d == StPresent);
    busy_d  = (state_d != StIdle) || done_d;
    data1_d = (state_q == StRd1) ? mem_rd_data : sc_mem_rd_data1;
    data2_d = (state_q == StCap1) ? mem_rd_data : sc_mem_rd_data2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= StIdle;
      rd_base_q          <= '0;
      wt_base_q          <= '0;
      num_groups_q       <= '0;
      g_q                <= '0;
      arm_q              <= 1'b0;
      k_q                <= 3'd0;
      mem_rd_en          <= 1'b0;
      mem_rd_addr        <= '0;
      mem_wt_en          <= 1'b0;
      mem_wt_addr        <= '0;
      sc_mem_rd_data1    <= '0;
      sc_mem_rd_data2    <= '0;
      sc_mem_rd_data_rdy <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      state_q            <= state_d;
      rd_base_q          <= rd_base_d;
      wt_base_q          <= wt_base_d;
      num_groups_q       <= num_groups_d;
      g_q                <= g_d;
      arm_q              <= arm_d;
      k_q                <= k_d;
      mem_rd_en          <= rd_en_d;
      mem_rd_addr        <= rd_addr_d;
      mem_wt_en          <= wt_en_d;
      mem_wt_addr        <= wt_addr_d;
      sc_mem_rd_data1    <= data1_d;
      sc_mem_rd_data2    <= data2_d;
      sc_mem_rd_data_rdy <= rdy_d;
      busy               <= busy_d;
      done               <= done_d;
    end
  end

endmodule

// File: tb/tb_divider_mem_ctrl.sv
`timescale 1ns / 1ps
// Bench for divider_mem_ctrl: scripted timing scenarios plus randomized passes checked against
// address/data/timing expectations derived from the pass parameters and a memory image.
module tb_divider_mem_ctrl;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [7:0]   rd_base, wt_base, num_groups;
  logic         mem_rd_en, mem_wt_en;
  logic [7:0]   mem_rd_addr, mem_wt_addr;
  logic [127:0] mem_rd_data;
  logic [7:0]   div_done;
  logic [127:0] sc_mem_rd_data1, sc_mem_rd_data2;
  logic         sc_mem_rd_data_rdy, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  int overlap = 0;
  int div_cnt = 0;

  logic [127:0] mem [256];

  logic [7:0]   rd_a[$], wt_a[$];
  int           rd_c[$], wt_c[$], rdy_c[$], done_c[$], raise_c[$];
  logic [127:0] rdy_d1[$], rdy_d2[$];

  divider_mem_ctrl #(.ADDR_W(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .rd_base            (rd_base),
    .wt_base            (wt_base),
    .num_groups         (num_groups),
    .mem_rd_en          (mem_rd_en),
    .mem_rd_addr        (mem_rd_addr),
    .mem_rd_data        (mem_rd_data),
    .mem_wt_en          (mem_wt_en),
    .mem_wt_addr        (mem_wt_addr),
    .div_done           (div_done),
    .sc_mem_rd_data1    (sc_mem_rd_data1),
    .sc_mem_rd_data2    (sc_mem_rd_data2),
    .sc_mem_rd_data_rdy (sc_mem_rd_data_rdy),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scratch memory: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    else           mem_rd_data <= {$urandom, $urandom, $urandom, $urandom};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge, log the DUT outputs of that cycle, drop start.
  task automatic tick();
    @(negedge clk);
    if (mem_rd_en) begin rd_a.push_back(mem_rd_addr); rd_c.push_back(cyc - t0); end
    if (mem_wt_en) begin wt_a.push_back(mem_wt_addr); wt_c.push_back(cyc - t0); end
    if (sc_mem_rd_data_rdy) begin
      rdy_c.push_back(cyc - t0);
      rdy_d1.push_back(sc_mem_rd_data1);
      rdy_d2.push_back(sc_mem_rd_data2);
    end
    if (done) done_c.push_back(cyc - t0);
    if (mem_rd_en && mem_wt_en) overlap++;
    start = 1'b0;
  endtask

  task automatic begin_pass(input logic [7:0] rb, input logic [7:0] wb, input logic [7:0] ng);
    tick();
    rd_a.delete(); wt_a.delete(); rd_c.delete(); wt_c.delete(); rdy_c.delete();
    rdy_d1.delete(); rdy_d2.delete(); done_c.delete(); raise_c.delete();
    overlap    = 0;
    div_cnt    = 0;
    div_done   = 8'hFF;
    t0         = cyc;
    rd_base    = rb;
    wt_base    = wb;
    num_groups = ng;
    start      = 1'b1;
  endtask

  // Dividers: drop some flags when data is presented, raise all of them a few cycles later.
  task automatic run_auto(input int max_cyc, output bit finished);
    finished = 1'b0;
    for (int i = 0; i < max_cyc && !finished; i++) begin
      tick();
      if (done) finished = 1'b1;
      if (sc_mem_rd_data_rdy) begin
        div_done = 8'($urandom) & 8'hFE;
        div_cnt  = $urandom_range(2, 8);
      end else if (div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0) begin
          div_done = 8'hFF;
          raise_c.push_back(cyc - t0);
        end
      end
    end
  endtask

  task automatic check_pass(input string name, input logic [7:0] rb, input logic [7:0] wb,
                            input int ng);
    bit         ok;
    logic [7:0] a;
    int         exp_rd;

    n_tests++;
    ok = (rd_a.size() == 2 * ng);
    for (int i = 0; ok && i < 2 * ng; i++) begin
      a = rb + 8'(i);
      if (rd_a[i] !== a) ok = 1'b0;
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL %s rd_addr: got %p, required %0d lines from %h", name, rd_a, 2 * ng, rb);
    end

    n_tests++;
    ok = (wt_a.size() == 2 * ng);
    for (int i = 0; ok && i < 2 * ng; i++) begin
      a = wb + 8'(i);
      if (wt_a[i] !== a) ok = 1'b0;
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL %s wt_addr: got %p, required %0d lines from %h", name, wt_a, 2 * ng, wb);
    end

    n_tests++;
    ok = (rdy_c.size() == ng);
    for (int g = 0; ok && g < ng; g++) begin
      a = rb + 8'(2 * g);
      if (rdy_d1[g] !== mem[a]) ok = 1'b0;
      a = a + 8'd1;
      if (rdy_d2[g] !== mem[a]) ok = 1'b0;
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL %s rdy_data: got %0d pulses, required %0d with lines from %h",
               name, rdy_c.size(), ng, rb);
    end

    // Timing: each group starts 6 cycles after the previous raise of all flags.
    n_tests++;
    ok = (raise_c.size() == ng) && (rd_c.size() == 2 * ng) && (wt_c.size() == 2 * ng);
    for (int g = 0; ok && g < ng; g++) begin
      exp_rd = (g == 0) ? 1 : raise_c[g-1] + 6;
      if (rd_c[2*g] != exp_rd || rd_c[2*g+1] != exp_rd + 1) ok = 1'b0;
      if (rdy_c[g] != exp_rd + 3) ok = 1'b0;
      if (wt_c[2*g] != raise_c[g] + 1 || wt_c[2*g+1] != raise_c[g] + 4) ok = 1'b0;
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timing: rd %p rdy %p wt %p, raises %p", name, rd_c, rdy_c, wt_c, raise_c);
    end

    n_tests++;
    if (done_c.size() != 1 || raise_c.size() != ng || done_c[0] != raise_c[ng-1] + 6) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %p, raises %p, required last raise + 6", name, done_c,
               raise_c);
    end

    n_tests++;
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL %s rd_wt_overlap: got %0d cycles, required 0", name, overlap);
    end
  endtask

  task automatic auto_pass(input string name, input logic [7:0] rb, input logic [7:0] wb,
                           input int ng);
    bit fin;
    begin_pass(rb, wb, 8'(ng));
    run_auto(40 * ng + 40, fin);
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s finish: got no done within bound, required done", name);
    end else begin
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy_at_done: got %b, required 1", name, busy);
      end
      tick();
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy_after_done: got %b, required 0", name, busy);
      end
    end
    check_pass(name, rb, wb, ng);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; div_done = 8'hFF;
    rd_base = '0; wt_base = '0; num_groups = '0;
    repeat (3) tick();
    n_tests++;
    if ({mem_rd_en, mem_rd_addr, mem_wt_en, mem_wt_addr, sc_mem_rd_data_rdy, busy, done}
        !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b/%h/%b/%h/%b/%b/%b, required all 0", mem_rd_en,
               mem_rd_addr, mem_wt_en, mem_wt_addr, sc_mem_rd_data_rdy, busy, done);
    end
    n_tests++;
    if ({sc_mem_rd_data1, sc_mem_rd_data2} !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h, required 0", sc_mem_rd_data1, sc_mem_rd_data2);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_group();
    mem[8'h10] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem[8'h11] = {32'd8, 32'd7, 32'd6, 32'd5};
    begin_pass(8'h10, 8'h40, 8'd1);
    for (int r = 1; r <= 30; r++) begin
      tick();
      if (r == 1) begin
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single busy_c1: got %b, required 1", busy); end
      end
      if (r == 27) begin
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single busy_c27: got %b, required 0", busy); end
      end
      if (r == 7)  div_done = 8'h00;
      if (r == 20) div_done = 8'hFF;
    end
    n_tests++;
    if (rd_a.size() != 2 || rd_a[0] !== 8'h10 || rd_a[1] !== 8'h11 || rd_c[0] != 1 || rd_c[1] != 2)
    begin
      n_fail++;
      $display("FAIL single reads: got %p at %p, required 10,11 at 1,2", rd_a, rd_c);
    end
    n_tests++;
    if (rdy_c.size() != 1 || rdy_c[0] != 4 || rdy_d1[0] !== {32'd4, 32'd3, 32'd2, 32'd1} ||
        rdy_d2[0] !== {32'd8, 32'd7, 32'd6, 32'd5}) begin
      n_fail++;
      $display("FAIL single rdy: got %p data1 %h, required cycle 4 data1 %h", rdy_c,
               sc_mem_rd_data1, {32'd4, 32'd3, 32'd2, 32'd1});
    end
    n_tests++;
    if (wt_a.size() != 2 || wt_a[0] !== 8'h40 || wt_a[1] !== 8'h41 || wt_c[0] != 21 ||
        wt_c[1] != 24) begin
      n_fail++;
      $display("FAIL single writes: got %p at %p, required 40,41 at 21,24", wt_a, wt_c);
    end
    n_tests++;
    if (done_c.size() != 1 || done_c[0] != 26) begin
      n_fail++;
      $display("FAIL single done: got %p, required 26", done_c);
    end
  endtask

  task automatic test_stale_done();
    logic [7:0] rb, wb;
    rb = 8'($urandom); wb = 8'($urandom);
    begin_pass(rb, wb, 8'd1);
    for (int r = 1; r <= 32; r++) begin
      tick();
      if (r == 21) div_done = 8'h0F;
      if (r == 22) div_done = 8'hFF;
    end
    n_tests++;
    if (wt_a.size() != 2 || wt_c[0] != 23 || wt_c[1] != 26 || wt_a[0] !== wb) begin
      n_fail++;
      $display("FAIL stale writes: got %p at %p, required %h.. at 23,26", wt_a, wt_c, wb);
    end
    n_tests++;
    if (done_c.size() != 1 || done_c[0] != 28) begin
      n_fail++;
      $display("FAIL stale done: got %p, required 28", done_c);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rb, wb;
    rb = 8'($urandom); wb = 8'($urandom);
    begin_pass(rb, wb, 8'd2);
    for (int r = 1; r <= 25; r++) begin
      tick();
      if (r == 12) begin
        n_tests++;
        if ({mem_rd_en, mem_rd_addr, mem_wt_en, mem_wt_addr, sc_mem_rd_data1, sc_mem_rd_data2,
             sc_mem_rd_data_rdy, busy, done} !== '0) begin
          n_fail++;
          $display("FAIL reset_mid outputs: got wt=%b rd=%b busy=%b d1=%h, required all 0",
                   mem_wt_en, mem_rd_en, busy, sc_mem_rd_data1);
        end
        reset = 1'b0;
      end
      if (r == 3) begin start = 1'b1; rd_base = rb ^ 8'h55; end
      if (r == 5)  div_done = 8'h00;
      if (r == 9)  div_done = 8'hFF;
      if (r == 11) reset = 1'b1;
      if (r == 15) div_done = 8'h00;
      if (r == 17) div_done = 8'hFF;
    end
    n_tests++;
    if (wt_a.size() != 1 || wt_c[0] != 10 || wt_a[0] !== wb) begin
      n_fail++;
      $display("FAIL reset_mid writes: got %p at %p, required %h at 10 only", wt_a, wt_c, wb);
    end
    n_tests++;
    if (rd_a.size() != 2 || rd_a[0] !== rb || rdy_c.size() != 1 || done_c.size() != 0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid reads: got %p rdy %0d done %0d busy %b, required 2 reads from %h",
               rd_a, rdy_c.size(), done_c.size(), busy, rb);
    end
  endtask

  task automatic test_zero_groups();
    begin_pass(8'($urandom), 8'($urandom), 8'd0);
    for (int r = 1; r <= 6; r++) begin
      tick();
      if (r == 1) begin
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL zero busy_c1: got %b, required 1", busy); end
      end
      if (r == 3) begin
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL zero busy_c3: got %b, required 0", busy); end
      end
    end
    n_tests++;
    if (done_c.size() != 1 || done_c[0] != 2 || rd_a.size() != 0 || wt_a.size() != 0 ||
        rdy_c.size() != 0) begin
      n_fail++;
      $display("FAIL zero pass: got done %p rd %0d wt %0d rdy %0d, required done 2 only", done_c,
               rd_a.size(), wt_a.size(), rdy_c.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_single_group();
    auto_pass("multi3", 8'h10, 8'h40, 3);
    test_stale_done();
    auto_pass("wrap", 8'hFF, 8'hFE, 1);
    test_reset_mid();
    test_zero_groups();
    for (int n = 0; n < 6; n++) begin
      auto_pass("random", 8'($urandom), 8'($urandom), int'($urandom_range(1, 4)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
